// File: rtl/aes_key_expand_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aes_pkg                                                     |
// | Brief  : Shared constants, state type and helpers for the AES-128    |
// |          key schedule.                                               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  // Pipeline depth of the byte sbox; the round timer compares against this.
  localparam int SBOX_LAT = 6;
  // Number of AES-128 rounds (round keys rk1..rk10 follow rk0).
  localparam int NR = 10;
  // First round constant of the schedule.
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SUBW = 1'b1
  } kx_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic byte rotation {b0,b1,b2,b3} -> {b1,b2,b3,b0}, b0 being the MSB.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aes_key_expand_if                                           |
// | Brief  : Request/round-key bundle between a key-schedule consumer    |
// |          (master) and the key expander (slave).                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface aes_key_expand_if;

  logic [127:0] key_in;
  logic         start;
  logic         busy;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         done;

  modport master (
    output key_in, start,
    input  busy, rk, rk_idx, rk_valid, done
  );

  modport slave (
    input  key_in, start,
    output busy, rk, rk_idx, rk_valid, done
  );

endinterface
`default_nettype wire

// File: rtl/aes_key_expand_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sbox                                                        |
// | Brief  : AES forward S-box on one byte, pipelined to SBOX_LAT        |
// |          cycles. Active-high synchronous reset clears the pipeline.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Carry-less GF(2^8) product built from repeated xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox_fn(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] pipe [SBOX_LAT];

  // Substitute on entry, then carry the result through the delay stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) pipe[i] <= 8'h00;
    end else begin
      pipe[0] <= sbox_fn(x);
      for (int i = 1; i < SBOX_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[SBOX_LAT-1];

endmodule
`default_nettype wire

// File: rtl/aes_key_expand_sub_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sub_word                                                    |
// | Brief  : 32-bit SubWord from four pipelined byte sboxes; latency is  |
// |          SBOX_LAT. rst is active-low here and inverted for the sbox. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sub_word
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic sbox_rst;

  assign sbox_rst = ~rst;

  for (genvar i = 0; i < 4; i++) begin : g_byte
    sbox u_sbox (
      .clk (clk),
      .rst (sbox_rst),
      .x   (x[8*i +: 8]),
      .y   (y[8*i +: 8])
    );
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aes_key_expand                                              |
// | Brief  : AES-128 key schedule. Emits rk0..rk10, one every 7 cycles,  |
// |          with SubWord computed by a pipelined sub_word block.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module aes_key_expand
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  aes_key_expand_if.slave  kx
);

  localparam int CNT_W = $clog2(SBOX_LAT + 1);

  kx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       rcon;
  logic [127:0]     rk_q;
  logic [3:0]       idx_q;
  logic             valid_q;
  logic             done_q;

  logic [31:0]      sw_in;
  logic [31:0]      sw_out;
  logic [31:0]      t;
  logic [31:0]      w0n;
  logic [31:0]      w1n;
  logic [31:0]      w2n;
  logic [31:0]      w3n;

  // The sbox input comes straight from rk_q, so it stays constant for the
  // whole round and the pipeline output is settled once cnt reaches SBOX_LAT.
  assign sw_in = rot_word(rk_q[31:0]);

  sub_word u_sub_word (
    .clk (clk),
    .rst (rst),
    .x   (sw_in),
    .y   (sw_out)
  );

  // Next round key: rcon-mixed SubWord result rippled through the four words.
  always_comb begin
    t   = sw_out ^ {rcon, 24'h000000};
    w0n = rk_q[127:96] ^ t;
    w1n = rk_q[95:64]  ^ w0n;
    w2n = rk_q[63:32]  ^ w1n;
    w3n = rk_q[31:0]   ^ w2n;
  end

  // Control FSM with the round timer, rcon and the round-key register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rcon    <= 8'h00;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (kx.start) begin
            rk_q    <= kx.key_in;
            idx_q   <= 4'd0;
            valid_q <= 1'b1;
            rcon    <= RCON_INIT;
            cnt     <= '0;
            state   <= SUBW;
          end
        end
        SUBW: begin
          if (cnt == CNT_W'(SBOX_LAT)) begin
            rk_q    <= {w0n, w1n, w2n, w3n};
            idx_q   <= idx_q + 4'd1;
            valid_q <= 1'b1;
            cnt     <= '0;
            rcon    <= xtime(rcon);
            if (idx_q + 4'd1 == 4'(NR)) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kx.busy     = (state != IDLE);
  assign kx.rk       = rk_q;
  assign kx.rk_idx   = idx_q;
  assign kx.rk_valid = valid_q;
  assign kx.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_aes_key_expand                                           |
// | Brief  : Randomised scoreboard bench for aes_key_expand against a    |
// |          FIPS-197 style key-schedule model.                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_aes_key_expand;

  typedef struct {
    int           cyc;
    logic [3:0]   idx;
    logic [127:0] rk;
    bit           done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;

  exp_t         sb[$];
  logic [7:0]   sbox_tab [256];
  logic [127:0] cap_rk [11];

  aes_key_expand_if ifc ();

  aes_key_expand dut (
    .clk (clk),
    .rst (rst),
    .kx  (ifc)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // S-box table from the generator-3 walk: p runs over powers of 3, q over
  // the matching inverses, and the affine map is applied to q.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  // Textbook word-array key expansion; queue rk0..rk10 with their cycles.
  task automatic push_model(input logic [127:0] key, input int c0);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc_tab [10];
    exp_t        e;
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc_tab[i/4 - 1], 24'h000000};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) begin
      e.cyc  = c0 + 1 + 7*r;
      e.idx  = 4'(r);
      e.rk   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.done = (r == 10);
      sb.push_back(e);
    end
  endtask

  // Monitor: flag overdue entries, then match every rk_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse: idx %0d due in cycle %0d, not observed by cycle %0d", e.idx, e.cyc, cyc);
    end
    if (ifc.rk_valid) begin
      n_pulses++;
      if (ifc.rk_idx <= 4'd10) cap_rk[ifc.rk_idx] = ifc.rk;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: rk_idx %0d rk %h in cycle %0d", ifc.rk_idx, ifc.rk, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", 128'(cyc), 128'(e.cyc));
        chk("rk_idx", 128'(ifc.rk_idx), 128'(e.idx));
        chk("rk", ifc.rk, e.rk);
        chk("done", 128'(ifc.done), 128'(e.done));
        if (e.idx == 4'd0)  chk("busy_at_rk0", 128'(ifc.busy), 128'(1));
        if (e.idx == 4'd10) chk("busy_at_rk10", 128'(ifc.busy), 128'(0));
      end
    end else if (ifc.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_without_valid: done=1 rk_valid=0 in cycle %0d", cyc);
    end
  end

  // Called at posedge+1 with busy low (or in the cycle a held start is
  // accepted). Returns at posedge+1 of cycle 71, or of the cycle after a
  // mid-run reset when rst_at > 0.
  task automatic run_exp(input logic [127:0] key, input bit poke, input bit hold, input int rst_at);
    int c0;
    ifc.key_in = key;
    ifc.start  = 1'b1;
    c0 = cyc;
    push_model(key, c0);
    for (int k = 1; k <= 71; k++) begin
      @(posedge clk);
      #1;
      ifc.key_in = rand128();
      ifc.start  = hold || (k == 71 ? 1'b0 : (poke && (k == 3 || k == 20 || k == 50)));
      if (rst_at > 0 && k == rst_at) begin
        rst       = 1'b0;
        ifc.start = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_rk", ifc.rk, 128'h0);
        chk("rst_mid_idx", 128'(ifc.rk_idx), 128'h0);
        chk("rst_mid_valid", 128'(ifc.rk_valid), 128'h0);
        chk("rst_mid_done", 128'(ifc.done), 128'h0);
        chk("rst_mid_busy", 128'(ifc.busy), 128'h0);
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: %0d expected round keys never appeared", sb.size());
    sb.delete();
  endtask

  initial begin
    int p0;
    build_sbox();
    ifc.key_in = '0;
    ifc.start  = 1'b0;
    rst        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rk", ifc.rk, 128'h0);
    chk("reset_idx", 128'(ifc.rk_idx), 128'h0);
    chk("reset_valid", 128'(ifc.rk_valid), 128'h0);
    chk("reset_done", 128'(ifc.done), 128'h0);
    chk("reset_busy", 128'(ifc.busy), 128'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 known-answer key.
    for (int i = 0; i < 11; i++) cap_rk[i] = '0;
    run_exp(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 0);
    wait_drain();
    chk("fips_rk1", cap_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key: known answers and exactly 11 pulses.
    for (int i = 0; i < 11; i++) cap_rk[i] = '1;
    p0 = n_pulses;
    run_exp(128'h0, 1'b0, 1'b0, 0);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    chk("zero_rk1", cap_rk[1], {4{32'h62636363}});
    chk("zero_rk10", cap_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_pulse_count", 128'(n_pulses - p0), 128'(11));

    // start pulses and key_in churn while busy must be ignored.
    run_exp(rand128(), 1'b1, 1'b0, 0);
    wait_drain();

    // Reset in cycle 30, then a clean expansion right after.
    run_exp(rand128(), 1'b0, 1'b0, 30);
    run_exp(rand128(), 1'b0, 1'b0, 0);
    wait_drain();

    // start held high: second expansion accepted in cycle 71.
    run_exp(rand128(), 1'b0, 1'b1, 0);
    run_exp(rand128(), 1'b0, 1'b0, 0);
    wait_drain();

    // A few more random keys, mixing in ignored start pulses.
    for (int n = 0; n < 4; n++) begin
      run_exp(rand128(), n[0], 1'b0, 0);
      wait_drain();
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
